lamp_disc_shader: RTL and testbench

//  Pipelined pixel shader for the traffic-light lamps on the junction VGA display. For every streamed

---
 rtl/lamp_disc_shader.sv | 186 ++++++++++++++++++
 tb/tb_lamp_disc_shader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/lamp_disc_shader.sv
// rtl/lamp_disc_shader.sv - three-stage lamp disc/ring pixel shader with double-buffered geometry and amber blink
module lamp_disc_shader #(
    parameter int             NUM_LAMPS = 3,
    parameter int             X_W       = 8,
    parameter int             Y_W       = 9,
    parameter int             R_W       = 9,
    parameter int             COL_W     = 3,
    parameter int             RING_MODE = 0,
    parameter int             RING_T    = 2,
    parameter int             BLINK_FR  = 30,
    parameter logic [COL_W-1:0] BG_COL  = 3'b000,
    parameter logic [COL_W-1:0] OFF_COL = 3'b000,
    parameter logic [COL_W-1:0] RED_COL = 3'b100,
    parameter logic [COL_W-1:0] AMB_COL = 3'b110,
    parameter logic [COL_W-1:0] GRN_COL = 3'b010,
    localparam int            IDX_W     = (NUM_LAMPS > 1) ? $clog2(NUM_LAMPS) : 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   frame_start_i,
    input  logic                   pix_valid_i,
    input  logic [X_W-1:0]         pix_x_i,
    input  logic [Y_W-1:0]         pix_y_i,
    input  logic [2*NUM_LAMPS-1:0] light_state_i,
    input  logic                   cfg_we_i,
    input  logic [IDX_W-1:0]       cfg_idx_i,
    input  logic [X_W-1:0]         cfg_cx_i,
    input  logic [Y_W-1:0]         cfg_cy_i,
    input  logic [R_W-1:0]         cfg_r_i,
    output logic                   out_valid_o,
    output logic [COL_W-1:0]       out_col_o,
    output logic                   out_hit_o,
    output logic [IDX_W-1:0]       out_idx_o
);
    localparam int M_W   = (X_W > Y_W) ? X_W : Y_W;
    localparam int D_W   = M_W + 2;
    localparam int SQ_W  = 2 * (M_W + 1) + 1;
    localparam int R2_W  = 2 * R_W;
    localparam int C_W   = (SQ_W > R2_W) ? SQ_W : R2_W;
    localparam int CNT_W = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;

    logic [X_W-1:0]  sh_cx_q  [NUM_LAMPS];
    logic [X_W-1:0]  sh_cx_d  [NUM_LAMPS];
    logic [Y_W-1:0]  sh_cy_q  [NUM_LAMPS];
    logic [Y_W-1:0]  sh_cy_d  [NUM_LAMPS];
    logic [R_W-1:0]  sh_r_q   [NUM_LAMPS];
    logic [R_W-1:0]  sh_r_d   [NUM_LAMPS];
    logic [R_W-1:0]  rin_d    [NUM_LAMPS];
    logic [X_W-1:0]  act_cx_q [NUM_LAMPS];
    logic [Y_W-1:0]  act_cy_q [NUM_LAMPS];
    logic [R2_W-1:0] r2_q     [NUM_LAMPS];
    logic [R2_W-1:0] ri2_q    [NUM_LAMPS];

    logic signed [D_W-1:0]  dx_d [NUM_LAMPS];
    logic signed [D_W-1:0]  dy_d [NUM_LAMPS];
    logic signed [D_W-1:0]  dx_q [NUM_LAMPS];
    logic signed [D_W-1:0]  dy_q [NUM_LAMPS];
    logic signed [SQ_W-1:0] ex_w [NUM_LAMPS];
    logic signed [SQ_W-1:0] ey_w [NUM_LAMPS];
    logic [SQ_W-1:0]        sq_d [NUM_LAMPS];
    logic [SQ_W-1:0]        sq_q [NUM_LAMPS];

    logic                   valid_s1_q, valid_s2_q;
    logic [2*NUM_LAMPS-1:0] st_s1_q, st_s2_q;
    logic                   ph_s1_q, ph_s2_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   phase_q;

    logic                   hit_any;
    logic [IDX_W-1:0]       win_idx;
    logic [1:0]             win_st;
    logic [COL_W-1:0]       col_d;

    // A write coinciding with frame_start merges here first so the commit sees it.
    always_comb begin
        for (int i = 0; i < NUM_LAMPS; i++) begin
            sh_cx_d[i] = sh_cx_q[i];
            sh_cy_d[i] = sh_cy_q[i];
            sh_r_d[i]  = sh_r_q[i];
            if (cfg_we_i && (cfg_idx_i == IDX_W'(i))) begin
                sh_cx_d[i] = cfg_cx_i;
                sh_cy_d[i] = cfg_cy_i;
                sh_r_d[i]  = cfg_r_i;
            end
            rin_d[i] = (sh_r_d[i] > R_W'(RING_T)) ? (sh_r_d[i] - R_W'(RING_T)) : '0;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_LAMPS; i++) begin
            dx_d[i] = $signed({{(D_W-X_W){1'b0}}, pix_x_i}) - $signed({{(D_W-X_W){1'b0}}, act_cx_q[i]});
            dy_d[i] = $signed({{(D_W-Y_W){1'b0}}, pix_y_i}) - $signed({{(D_W-Y_W){1'b0}}, act_cy_q[i]});
            ex_w[i] = SQ_W'(dx_q[i]);
            ey_w[i] = SQ_W'(dy_q[i]);
            sq_d[i] = unsigned'(ex_w[i] * ex_w[i] + ey_w[i] * ey_w[i]);
        end
    end

    // Walk from the top index down so the lowest-index hit overwrites the rest.
    always_comb begin
        hit_any = 1'b0;
        win_idx = '0;
        win_st  = 2'b00;
        for (int i = NUM_LAMPS - 1; i >= 0; i--) begin
            if ((C_W'(sq_q[i]) < C_W'(r2_q[i])) &&
                ((RING_MODE == 0) || (C_W'(sq_q[i]) >= C_W'(ri2_q[i])))) begin
                hit_any = 1'b1;
                win_idx = IDX_W'(i);
                win_st  = st_s2_q[2*i +: 2];
            end
        end
        col_d = BG_COL;
        if (hit_any) begin
            case (win_st)
                2'b00: col_d = OFF_COL;
                2'b01: col_d = RED_COL;
                2'b10: col_d = ph_s2_q ? OFF_COL : AMB_COL;
                2'b11: col_d = GRN_COL;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_LAMPS; i++) begin
                sh_cx_q[i]  <= '0;
                sh_cy_q[i]  <= '0;
                sh_r_q[i]   <= '0;
                act_cx_q[i] <= '0;
                act_cy_q[i] <= '0;
                r2_q[i]     <= '0;
                ri2_q[i]    <= '0;
                dx_q[i]     <= '0;
                dy_q[i]     <= '0;
                sq_q[i]     <= '0;
            end
            valid_s1_q  <= 1'b0;
            valid_s2_q  <= 1'b0;
            st_s1_q     <= '0;
            st_s2_q     <= '0;
            ph_s1_q     <= 1'b0;
            ph_s2_q     <= 1'b0;
            cnt_q       <= '0;
            phase_q     <= 1'b0;
            out_valid_o <= 1'b0;
            out_col_o   <= '0;
            out_hit_o   <= 1'b0;
            out_idx_o   <= '0;
        end else begin
            for (int i = 0; i < NUM_LAMPS; i++) begin
                sh_cx_q[i] <= sh_cx_d[i];
                sh_cy_q[i] <= sh_cy_d[i];
                sh_r_q[i]  <= sh_r_d[i];
                if (frame_start_i) begin
                    act_cx_q[i] <= sh_cx_d[i];
                    act_cy_q[i] <= sh_cy_d[i];
                    r2_q[i]     <= R2_W'(sh_r_d[i]) * R2_W'(sh_r_d[i]);
                    ri2_q[i]    <= R2_W'(rin_d[i]) * R2_W'(rin_d[i]);
                end
                dx_q[i] <= dx_d[i];
                dy_q[i] <= dy_d[i];
                sq_q[i] <= sq_d[i];
            end
            if (frame_start_i) begin
                if (cnt_q == CNT_W'(BLINK_FR - 1)) begin
                    cnt_q   <= '0;
                    phase_q <= ~phase_q;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
            valid_s1_q  <= pix_valid_i;
            st_s1_q     <= light_state_i;
            ph_s1_q     <= phase_q;
            valid_s2_q  <= valid_s1_q;
            st_s2_q     <= st_s1_q;
            ph_s2_q     <= ph_s1_q;
            out_valid_o <= valid_s2_q;
            if (valid_s2_q) begin
                out_col_o <= col_d;
                out_hit_o <= hit_any;
                out_idx_o <= win_idx;
            end
        end
    end
endmodule

// File: tb/tb_lamp_disc_shader.sv
// tb/tb_lamp_disc_shader.sv - directed checks of disc and ring shader instances
module tb_lamp_disc_shader;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_start = 1'b0;
    logic       pix_valid = 1'b0;
    logic [7:0] pix_x = '0;
    logic [8:0] pix_y = '0;
    logic [5:0] light_state = '0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_idx = '0;
    logic [7:0] cfg_cx = '0;
    logic [8:0] cfg_cy = '0;
    logic [8:0] cfg_r = '0;

    logic       d_valid, d_hit, r_valid, r_hit;
    logic [2:0] d_col, r_col;
    logic [1:0] d_idx, r_idx;

    int total = 0;
    int bad = 0;
    logic [2:0] blink_exp [1:6];

    lamp_disc_shader #(.BLINK_FR(2)) u_disc (
        .clk_i(clk), .reset_i(reset), .frame_start_i(frame_start),
        .pix_valid_i(pix_valid), .pix_x_i(pix_x), .pix_y_i(pix_y),
        .light_state_i(light_state), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx),
        .cfg_cx_i(cfg_cx), .cfg_cy_i(cfg_cy), .cfg_r_i(cfg_r),
        .out_valid_o(d_valid), .out_col_o(d_col), .out_hit_o(d_hit), .out_idx_o(d_idx)
    );

    lamp_disc_shader #(.RING_MODE(1), .RING_T(2), .BLINK_FR(2)) u_ring (
        .clk_i(clk), .reset_i(reset), .frame_start_i(frame_start),
        .pix_valid_i(pix_valid), .pix_x_i(pix_x), .pix_y_i(pix_y),
        .light_state_i(light_state), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx),
        .cfg_cx_i(cfg_cx), .cfg_cy_i(cfg_cy), .cfg_r_i(cfg_r),
        .out_valid_o(r_valid), .out_col_o(r_col), .out_hit_o(r_hit), .out_idx_o(r_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] idx, input logic [7:0] cx, input logic [8:0] cy, input logic [8:0] r);
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = idx; cfg_cx = cx; cfg_cy = cy; cfg_r = r;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic fstart();
        @(negedge clk);
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic pix(input logic [7:0] x, input logic [8:0] y);
        @(negedge clk);
        pix_x = x; pix_y = y; pix_valid = 1'b1;
        @(posedge clk); #1;
        pix_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        blink_exp[1] = 3'b110; blink_exp[2] = 3'b000; blink_exp[3] = 3'b000;
        blink_exp[4] = 3'b110; blink_exp[5] = 3'b110; blink_exp[6] = 3'b000;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", d_valid, 0);
        chk("rst_col", d_col, 0);
        chk("rst_hit", d_hit, 0);
        chk("rst_idx", d_idx, 0);
        @(negedge clk);
        reset = 1'b0;

        // disc
        light_state = 6'b000011;
        cfg(0, 50, 100, 10);
        fstart();
        pix(59, 100);
        chk("disc_in_valid", d_valid, 1);
        chk("disc_in_hit", d_hit, 1);
        chk("disc_in_col", d_col, 3'b010);
        pix(60, 100);
        chk("disc_edge_hit", d_hit, 0);
        chk("disc_edge_col", d_col, 3'b000);
        chk("disc_edge_idx", d_idx, 0);

        // shadow bank
        cfg(0, 50, 100, 30);
        pix(70, 100);
        chk("shadow_pre_hit", d_hit, 0);
        fstart();
        pix(70, 100);
        chk("shadow_post_hit", d_hit, 1);
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = 0; cfg_cx = 50; cfg_cy = 100; cfg_r = 5;
        frame_start = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0; frame_start = 1'b0;
        pix(70, 100);
        chk("coinc_far_hit", d_hit, 0);
        pix(54, 100);
        chk("coinc_near_hit", d_hit, 1);

        // overlap / priority
        light_state = 6'b001101;
        cfg(0, 20, 20, 5);
        cfg(1, 20, 20, 5);
        fstart();
        pix(20, 20);
        chk("ovl_hit", d_hit, 1);
        chk("ovl_idx", d_idx, 0);
        chk("ovl_col", d_col, 3'b100);
        chk("ovl_ring_centre_hit", r_hit, 0);
        cfg(1, 20, 20, 8);
        fstart();
        pix(26, 20);
        chk("ovl_l1_idx", d_idx, 1);
        chk("ovl_l1_col", d_col, 3'b010);
        light_state = 6'b001100;
        pix(20, 20);
        chk("off_hit", d_hit, 1);
        chk("off_col", d_col, 3'b000);

        // ring and extremes
        light_state = 6'b001111;
        cfg(0, 100, 100, 10);
        fstart();
        pix(105, 106);
        chk("ring_61_hit", r_hit, 0);
        chk("disc_61_hit", d_hit, 1);
        pix(108, 100);
        chk("ring_64_hit", r_hit, 1);
        chk("ring_64_col", r_col, 3'b010);
        pix(109, 100);
        chk("ring_81_hit", r_hit, 1);
        pix(110, 100);
        chk("ring_100_hit", r_hit, 0);
        chk("ring_100_col", r_col, 3'b000);
        cfg(0, 0, 0, 511);
        fstart();
        pix(255, 511);
        chk("ext_corner_disc", d_hit, 0);
        chk("ext_corner_ring", r_hit, 0);
        pix(0, 510);
        chk("ext_510_disc", d_hit, 1);
        chk("ext_510_ring", r_hit, 1);
        pix(255, 0);
        chk("ext_255_disc", d_hit, 1);
        chk("ext_255_ring", r_hit, 0);

        // reset mid-stream
        @(negedge clk);
        pix_x = 0; pix_y = 510; pix_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_valid", d_valid, 1);
        chk("pre_rst_hit", d_hit, 1);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("async_valid", d_valid, 0);
        chk("async_hit", d_hit, 0);
        chk("async_col", d_col, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("flush_1", d_valid, 0);
        @(posedge clk); #1;
        chk("flush_2", d_valid, 0);
        @(posedge clk); #1;
        chk("flush_3_valid", d_valid, 1);
        chk("flush_3_hit", d_hit, 0);
        pix_valid = 1'b0;
        fstart();
        pix(0, 0);
        chk("cleared_geom_hit", d_hit, 0);
        chk("cleared_geom_col", d_col, 0);

        // blink
        do_reset();
        light_state = 6'b000010;
        cfg(0, 50, 100, 10);
        for (int n = 1; n <= 6; n++) begin
            fstart();
            pix(50, 100);
            chk($sformatf("blink_f%0d", n), d_col, blink_exp[n]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
